// File: rtl/kernel_fetch_sequencer.sv
// Sequences the kernel fetch unit through a batch of N back-to-back kernels and
// hands each one to the MAC array. Optional fetch watchdog: define KFS_TIMEOUT_EN.
module kernel_fetch_sequencer #(
  parameter int ADDR_WIDTH      = 10,
  parameter int MAX_KERNEL_SIZE = 5,
  parameter int KCNT_WIDTH      = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cfg_valid,
  output logic                  cfg_ready,
  input  logic [ADDR_WIDTH-1:0] cfg_base_addr,
  input  logic [2:0]            cfg_ker_size,
  input  logic [KCNT_WIDTH-1:0] cfg_num_kernels,
  output logic                  kfu_start,
  output logic                  kfu_first_time,
  output logic [ADDR_WIDTH-1:0] kfu_base_addr,
  output logic [2:0]            kfu_ker_size,
  input  logic                  kfu_done,
  output logic                  ker_valid,
  input  logic                  ker_ready,
  output logic [KCNT_WIDTH-1:0] ker_index,
  output logic                  busy,
  output logic                  done,
  output logic                  err_cfg
`ifdef KFS_TIMEOUT_EN
  ,
  output logic                  fetch_timeout
`endif
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FIRST,
    S_FETCH,
    S_HOLD,
    S_NEXT,
    S_DONE
  } state_t;

  localparam logic [2:0] MAX_K = 3'(MAX_KERNEL_SIZE);

  state_t                state_reg;
  logic [ADDR_WIDTH-1:0] base_reg;
  logic [2:0]            ksize_reg;
  logic [KCNT_WIDTH-1:0] num_reg;
  logic [KCNT_WIDTH-1:0] index_reg;

  logic [5:0]            stride;
  logic [ADDR_WIDTH-1:0] next_base;
  logic [KCNT_WIDTH-1:0] next_index;
  logic                  cfg_illegal;

  // K*K never exceeds 49, so a 6-bit stride suffices; the add wraps modulo 2^ADDR_WIDTH.
  assign stride      = {3'b000, ksize_reg} * {3'b000, ksize_reg};
  assign next_base   = base_reg + {{(ADDR_WIDTH-6){1'b0}}, stride};
  assign next_index  = index_reg + 1'b1;
  assign cfg_illegal = (cfg_ker_size == 3'd0) || (cfg_ker_size > MAX_K) ||
                       (cfg_num_kernels == '0);

  assign kfu_base_addr = base_reg;
  assign kfu_ker_size  = ksize_reg;
  assign ker_index     = index_reg;

`ifdef KFS_TIMEOUT_EN
  logic [6:0] wd_cnt_reg;
  logic [6:0] wd_limit;
  logic       wd_expired;

  assign wd_limit   = {stride, 1'b0} + 7'd8;
  assign wd_expired = (wd_cnt_reg == wd_limit - 7'd1);
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg      <= S_IDLE;
      base_reg       <= '0;
      ksize_reg      <= '0;
      num_reg        <= '0;
      index_reg      <= '0;
      cfg_ready      <= 1'b1;
      kfu_start      <= 1'b0;
      kfu_first_time <= 1'b0;
      ker_valid      <= 1'b0;
      busy           <= 1'b0;
      done           <= 1'b0;
      err_cfg        <= 1'b0;
`ifdef KFS_TIMEOUT_EN
      wd_cnt_reg     <= '0;
      fetch_timeout  <= 1'b0;
`endif
    end else begin
      done    <= 1'b0;
      err_cfg <= 1'b0;
`ifdef KFS_TIMEOUT_EN
      fetch_timeout <= 1'b0;
`endif
      case (state_reg)
        S_IDLE: begin
          if (cfg_valid) begin
            base_reg  <= cfg_base_addr;
            ksize_reg <= cfg_ker_size;
            num_reg   <= cfg_num_kernels;
            index_reg <= '0;
            cfg_ready <= 1'b0;
            busy      <= 1'b1;
            if (cfg_illegal) begin
              state_reg <= S_DONE;
              done      <= 1'b1;
              err_cfg   <= 1'b1;
            end else begin
              state_reg      <= S_FIRST;
              kfu_start      <= 1'b1;
              kfu_first_time <= 1'b1;
`ifdef KFS_TIMEOUT_EN
              wd_cnt_reg     <= '0;
`endif
            end
          end
        end

        // A completion strobe during FIRST counts the same as one during FETCH.
        S_FIRST, S_FETCH: begin
          kfu_first_time <= 1'b0;
          if (kfu_done) begin
            state_reg <= S_HOLD;
            kfu_start <= 1'b0;
            ker_valid <= 1'b1;
`ifdef KFS_TIMEOUT_EN
          end else if (wd_expired) begin
            state_reg     <= S_DONE;
            kfu_start     <= 1'b0;
            fetch_timeout <= 1'b1;
            done          <= 1'b1;
`endif
          end else begin
            state_reg <= S_FETCH;
`ifdef KFS_TIMEOUT_EN
            wd_cnt_reg <= wd_cnt_reg + 7'd1;
`endif
          end
        end

        S_HOLD: begin
          if (ker_ready) begin
            state_reg <= S_NEXT;
            ker_valid <= 1'b0;
          end
        end

        S_NEXT: begin
          base_reg  <= next_base;
          index_reg <= next_index;
          if (next_index < num_reg) begin
            state_reg      <= S_FIRST;
            kfu_start      <= 1'b1;
            kfu_first_time <= 1'b1;
`ifdef KFS_TIMEOUT_EN
            wd_cnt_reg     <= '0;
`endif
          end else begin
            state_reg <= S_DONE;
            done      <= 1'b1;
          end
        end

        S_DONE: begin
          state_reg <= S_IDLE;
          cfg_ready <= 1'b1;
          busy      <= 1'b0;
        end

        default: begin
          state_reg <= S_IDLE;
          cfg_ready <= 1'b1;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_kernel_fetch_sequencer.sv
// Directed self-checking bench for kernel_fetch_sequencer; inputs change and
// outputs are sampled on the falling clock edge.
module tb_kernel_fetch_sequencer;

  logic       clk;
  logic       rst;
  logic       cfg_valid;
  logic       cfg_ready;
  logic [9:0] cfg_base_addr;
  logic [2:0] cfg_ker_size;
  logic [7:0] cfg_num_kernels;
  logic       kfu_start;
  logic       kfu_first_time;
  logic [9:0] kfu_base_addr;
  logic [2:0] kfu_ker_size;
  logic       kfu_done;
  logic       ker_valid;
  logic       ker_ready;
  logic [7:0] ker_index;
  logic       busy;
  logic       done;
  logic       err_cfg;
`ifdef KFS_TIMEOUT_EN
  logic       fetch_timeout;
`endif

  int passed = 0;
  int total  = 0;

  kernel_fetch_sequencer #(
    .ADDR_WIDTH(10),
    .MAX_KERNEL_SIZE(5),
    .KCNT_WIDTH(8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .cfg_valid(cfg_valid),
    .cfg_ready(cfg_ready),
    .cfg_base_addr(cfg_base_addr),
    .cfg_ker_size(cfg_ker_size),
    .cfg_num_kernels(cfg_num_kernels),
    .kfu_start(kfu_start),
    .kfu_first_time(kfu_first_time),
    .kfu_base_addr(kfu_base_addr),
    .kfu_ker_size(kfu_ker_size),
    .kfu_done(kfu_done),
    .ker_valid(ker_valid),
    .ker_ready(ker_ready),
    .ker_index(ker_index),
    .busy(busy),
    .done(done),
    .err_cfg(err_cfg)
`ifdef KFS_TIMEOUT_EN
    ,
    .fetch_timeout(fetch_timeout)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic test_reset();
    #12;
    total++; if (cfg_ready !== 1'b1) $display("FAIL reset_cfg_ready: got %b expected 1", cfg_ready); else passed++;
    total++; if ({kfu_start, kfu_first_time, ker_valid, busy, done, err_cfg} !== 6'b0)
      $display("FAIL reset_ctrl: got %b expected 000000", {kfu_start, kfu_first_time, ker_valid, busy, done, err_cfg}); else passed++;
    total++; if ({kfu_base_addr, kfu_ker_size, ker_index} !== 21'd0)
      $display("FAIL reset_data: got %h expected 0", {kfu_base_addr, kfu_ker_size, ker_index}); else passed++;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    total++; if ({cfg_ready, busy} !== 2'b10) $display("FAIL reset_idle: got %b expected 10", {cfg_ready, busy}); else passed++;
    $display("reset: done");
  endtask

  task automatic test_legal_batch();
    logic [9:0] exp_base;
    cfg_valid = 1'b1; cfg_base_addr = 10'h010; cfg_ker_size = 3'd3; cfg_num_kernels = 8'd3; ker_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      cfg_valid = 1'b0;
      exp_base = 10'(16 + 9 * k);
      total++; if ({kfu_start, kfu_first_time} !== 2'b11) $display("FAIL legal_first k=%0d: got %b expected 11", k, {kfu_start, kfu_first_time}); else passed++;
      total++; if (kfu_base_addr !== exp_base) $display("FAIL legal_base k=%0d: got %h expected %h", k, kfu_base_addr, exp_base); else passed++;
      total++; if (ker_index !== 8'(k)) $display("FAIL legal_index k=%0d: got %0d expected %0d", k, ker_index, k); else passed++;
      for (int c = 1; c <= 9; c++) begin
        @(negedge clk);
        if (c == 1) begin
          total++; if ({kfu_start, kfu_first_time, ker_valid} !== 3'b100)
            $display("FAIL legal_fetch k=%0d: got %b expected 100", k, {kfu_start, kfu_first_time, ker_valid}); else passed++;
        end
        if (c == 9) kfu_done = 1'b1;
      end
      @(negedge clk);
      kfu_done = 1'b0;
      total++; if ({ker_valid, kfu_start} !== 2'b10) $display("FAIL legal_hold k=%0d: got %b expected 10", k, {ker_valid, kfu_start}); else passed++;
      total++; if (ker_index !== 8'(k)) $display("FAIL legal_hold_index k=%0d: got %0d expected %0d", k, ker_index, k); else passed++;
      @(negedge clk);
      total++; if ({ker_valid, done} !== 2'b00) $display("FAIL legal_next k=%0d: got %b expected 00", k, {ker_valid, done}); else passed++;
      $display("legal: kernel %0d base %h index %0d", k, exp_base, k);
    end
    @(negedge clk);
    total++; if ({done, err_cfg, busy} !== 3'b101) $display("FAIL legal_done: got %b expected 101", {done, err_cfg, busy}); else passed++;
    @(negedge clk);
    total++; if ({done, cfg_ready, busy} !== 3'b010) $display("FAIL legal_idle: got %b expected 010", {done, cfg_ready, busy}); else passed++;
    ker_ready = 1'b0;
  endtask

  task automatic test_wrap();
    cfg_valid = 1'b1; cfg_base_addr = 10'h3F0; cfg_ker_size = 3'd5; cfg_num_kernels = 8'd2; ker_ready = 1'b1;
    @(negedge clk);
    cfg_valid = 1'b0;
    total++; if (kfu_base_addr !== 10'h3F0) $display("FAIL wrap_base0: got %h expected 3f0", kfu_base_addr); else passed++;
    total++; if (kfu_ker_size !== 3'd5) $display("FAIL wrap_ksize: got %0d expected 5", kfu_ker_size); else passed++;
    kfu_done = 1'b1;
    @(negedge clk);
    kfu_done = 1'b0;
    total++; if ({ker_valid, kfu_start} !== 2'b10) $display("FAIL wrap_done_in_first: got %b expected 10", {ker_valid, kfu_start}); else passed++;
    @(negedge clk);
    @(negedge clk);
    total++; if (kfu_base_addr !== 10'h009) $display("FAIL wrap_base1: got %h expected 009", kfu_base_addr); else passed++;
    total++; if ({kfu_first_time, ker_index} !== {1'b1, 8'd1}) $display("FAIL wrap_first1: got %h expected 101", {kfu_first_time, ker_index}); else passed++;
    kfu_done = 1'b1;
    @(negedge clk);
    kfu_done = 1'b0;
    @(negedge clk);
    @(negedge clk);
    total++; if (done !== 1'b1) $display("FAIL wrap_done: got %b expected 1", done); else passed++;
    @(negedge clk);
    ker_ready = 1'b0;
    $display("wrap: second base %h", 10'h009);
  endtask

  task automatic test_backpressure();
    cfg_valid = 1'b1; cfg_base_addr = 10'h020; cfg_ker_size = 3'd2; cfg_num_kernels = 8'd2; ker_ready = 1'b0;
    @(negedge clk);
    cfg_valid = 1'b0;
    @(negedge clk);
    kfu_done = 1'b1;
    @(negedge clk);
    kfu_done = 1'b0;
    for (int i = 0; i < 6; i++) begin
      total++; if ({ker_valid, kfu_start} !== 2'b10) $display("FAIL bp_hold i=%0d: got %b expected 10", i, {ker_valid, kfu_start}); else passed++;
      total++; if (kfu_ker_size !== 3'd2) $display("FAIL bp_busy_cfg i=%0d: got %0d expected 2", i, kfu_ker_size); else passed++;
      kfu_done = (i == 1);
      cfg_valid = 1'b1; cfg_ker_size = 3'd5; cfg_base_addr = 10'h300;
      @(negedge clk);
    end
    total++; if ({ker_valid, kfu_start, ker_index} !== 10'b10_0000_0000) $display("FAIL bp_hold_end: got %b expected 1000000000", {ker_valid, kfu_start, ker_index}); else passed++;
    cfg_valid = 1'b0; kfu_done = 1'b0; ker_ready = 1'b1;
    @(negedge clk);
    total++; if (ker_valid !== 1'b0) $display("FAIL bp_next: got %b expected 0", ker_valid); else passed++;
    @(negedge clk);
    total++; if ({kfu_base_addr, ker_index} !== {10'h024, 8'd1}) $display("FAIL bp_base1: got %h expected %h", {kfu_base_addr, ker_index}, {10'h024, 8'd1}); else passed++;
    kfu_done = 1'b1;
    @(negedge clk);
    kfu_done = 1'b0;
    @(negedge clk);
    @(negedge clk);
    total++; if ({done, err_cfg} !== 2'b10) $display("FAIL bp_done: got %b expected 10", {done, err_cfg}); else passed++;
    @(negedge clk);
    ker_ready = 1'b0;
    $display("backpressure: held 6 cycles, second base %h", 10'h024);
  endtask

  task automatic test_illegal();
    logic [2:0] k_t;
    logic [7:0] n_t;
    for (int i = 0; i < 3; i++) begin
      case (i)
        0:       begin k_t = 3'd0; n_t = 8'd4; end
        1:       begin k_t = 3'd6; n_t = 8'd1; end
        default: begin k_t = 3'd3; n_t = 8'd0; end
      endcase
      cfg_valid = 1'b1; cfg_ker_size = k_t; cfg_num_kernels = n_t; cfg_base_addr = 10'h100;
      @(negedge clk);
      cfg_valid = 1'b0;
      total++; if ({err_cfg, done, busy, kfu_start} !== 4'b1110) $display("FAIL illegal_pulse i=%0d: got %b expected 1110", i, {err_cfg, done, busy, kfu_start}); else passed++;
      @(negedge clk);
      total++; if ({err_cfg, done, busy, kfu_start, cfg_ready} !== 5'b00001) $display("FAIL illegal_after i=%0d: got %b expected 00001", i, {err_cfg, done, busy, kfu_start, cfg_ready}); else passed++;
      $display("illegal: K=%0d N=%0d", k_t, n_t);
    end
  endtask

  task automatic test_reset_mid_fetch();
    cfg_valid = 1'b1; cfg_base_addr = 10'h100; cfg_ker_size = 3'd3; cfg_num_kernels = 8'd3; ker_ready = 1'b1;
    @(negedge clk);
    cfg_valid = 1'b0; kfu_done = 1'b1;
    @(negedge clk);
    kfu_done = 1'b0;
    @(negedge clk);
    @(negedge clk);
    total++; if ({kfu_base_addr, ker_index} !== {10'h109, 8'd1}) $display("FAIL rst_k1: got %h expected %h", {kfu_base_addr, ker_index}, {10'h109, 8'd1}); else passed++;
    @(negedge clk);
    @(negedge clk);
    #1 rst = 1'b1;
    #1;
    total++; if ({cfg_ready, kfu_start, kfu_first_time, ker_valid, busy, done, err_cfg} !== 7'b1000000)
      $display("FAIL rst_async_ctrl: got %b expected 1000000", {cfg_ready, kfu_start, kfu_first_time, ker_valid, busy, done, err_cfg}); else passed++;
    total++; if ({kfu_base_addr, kfu_ker_size, ker_index} !== 21'd0) $display("FAIL rst_async_data: got %h expected 0", {kfu_base_addr, kfu_ker_size, ker_index}); else passed++;
    @(negedge clk);
    rst = 1'b0;
    cfg_valid = 1'b1; cfg_base_addr = 10'h055; cfg_ker_size = 3'd1; cfg_num_kernels = 8'd1;
    @(negedge clk);
    cfg_valid = 1'b0;
    total++; if ({kfu_start, kfu_first_time, kfu_base_addr, kfu_ker_size} !== {2'b11, 10'h055, 3'd1})
      $display("FAIL rst_new_cfg: got %h expected %h", {kfu_start, kfu_first_time, kfu_base_addr, kfu_ker_size}, {2'b11, 10'h055, 3'd1}); else passed++;
    kfu_done = 1'b1;
    @(negedge clk);
    kfu_done = 1'b0;
    @(negedge clk);
    @(negedge clk);
    total++; if (done !== 1'b1) $display("FAIL rst_new_done: got %b expected 1", done); else passed++;
    @(negedge clk);
    ker_ready = 1'b0;
    $display("reset_mid_fetch: aborted kernel 1, new batch accepted");
  endtask

`ifdef KFS_TIMEOUT_EN
  task automatic test_timeout();
    cfg_valid = 1'b1; cfg_base_addr = 10'h000; cfg_ker_size = 3'd2; cfg_num_kernels = 8'd1;
    @(negedge clk);
    cfg_valid = 1'b0;
    for (int c = 1; c <= 16; c++) begin
      @(negedge clk);
      if (c == 15) begin
        total++; if ({kfu_start, fetch_timeout} !== 2'b10) $display("FAIL to_pre: got %b expected 10", {kfu_start, fetch_timeout}); else passed++;
      end
    end
    total++; if ({fetch_timeout, done, err_cfg, kfu_start} !== 4'b1100) $display("FAIL to_pulse: got %b expected 1100", {fetch_timeout, done, err_cfg, kfu_start}); else passed++;
    @(negedge clk);
    total++; if ({fetch_timeout, done, cfg_ready, busy} !== 4'b0010) $display("FAIL to_idle: got %b expected 0010", {fetch_timeout, done, cfg_ready, busy}); else passed++;
    $display("timeout: pulse 16 cycles after FIRST");
  endtask
`endif

  initial begin
    rst = 1'b1; cfg_valid = 1'b0; cfg_base_addr = '0; cfg_ker_size = '0; cfg_num_kernels = '0;
    kfu_done = 1'b0; ker_ready = 1'b0;
    test_reset();
    test_legal_batch();
    test_wrap();
    test_backpressure();
    test_illegal();
    test_reset_mid_fetch();
`ifdef KFS_TIMEOUT_EN
    test_timeout();
`endif
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
